// File: rtl/canvas_fill.sv
// Rectangle-fill write engine for the H_LEN x V_LEN canvas: latches a rectangle and a colour,
// then streams one pixel write per pclk in row-major order on the canvas write port.
module canvas_fill #(
    parameter int DW    = 15,
    parameter int H_LEN = 200,
    parameter int V_LEN = 150
) (
    input  logic          pclk,
    input  logic          rstn,
    input  logic          start,
    input  logic          clr,
    input  logic [7:0]    x0,
    input  logic [7:0]    x1,
    input  logic [7:0]    y0,
    input  logic [7:0]    y1,
    input  logic [11:0]   color,
    output logic          we,
    output logic [DW-1:0] waddr,
    output logic [11:0]   wdata,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0]    X_MAX    = 8'(H_LEN - 1);
    localparam logic [7:0]    Y_MAX    = 8'(V_LEN - 1);
    localparam logic [DW-1:0] ROW_STEP = DW'(H_LEN);

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [1:0]    state;
    logic [7:0]    lx0, lx1, ly0, ly1;
    logic          lclr;
    logic [7:0]    xa, xb, yb;
    logic [7:0]    x, y;
    logic [DW-1:0] rowbase;

    logic [7:0]    nxa, nxb, nya, nyb;
    logic [DW-1:0] base;

    // Normalised corners from the latched (already clamped) request; only consumed in SETUP.
    always_comb begin
        nxa = lclr ? 8'd0  : min8(lx0, lx1);
        nxb = lclr ? X_MAX : max8(lx0, lx1);
        nya = lclr ? 8'd0  : min8(ly0, ly1);
        nyb = lclr ? Y_MAX : max8(ly0, ly1);
        base = DW'(nya) * ROW_STEP;
    end

    always_ff @(posedge pclk) begin
        if (!rstn) begin
            state <= S_IDLE;
            we    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lx0   <= clamp(x0, X_MAX);
                        lx1   <= clamp(x1, X_MAX);
                        ly0   <= clamp(y0, Y_MAX);
                        ly1   <= clamp(y1, Y_MAX);
                        lclr  <= clr;
                        wdata <= color;
                        busy  <= 1'b1;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    xa      <= nxa;
                    xb      <= nxb;
                    yb      <= nyb;
                    x       <= nxa;
                    y       <= nya;
                    rowbase <= base;
                    waddr   <= base + DW'(nxa);
                    we      <= 1'b1;
                    state   <= S_FILL;
                end
                S_FILL: begin
                    if (x == xb) begin
                        if (y == yb) begin
                            we    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            // Row wrap: step the row base instead of multiplying.
                            x       <= xa;
                            y       <= y + 8'd1;
                            rowbase <= rowbase + ROW_STEP;
                            waddr   <= rowbase + ROW_STEP + DW'(xa);
                        end
                    end else begin
                        x     <= x + 8'd1;
                        waddr <= waddr + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_canvas_fill.sv
// Self-checking bench for canvas_fill: a per-request pixel list model checked every cycle,
// directed corner cases pinned with literal values, then randomized fills.
module tb_canvas_fill;

    localparam int DW = 15;
    localparam int H  = 200;
    localparam int V  = 150;

    logic          pclk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          clr = 1'b0;
    logic [7:0]    x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic [11:0]   color = '0;
    logic          we;
    logic [DW-1:0] waddr;
    logic [11:0]   wdata;
    logic          busy;
    logic          done;

    always #5 pclk = ~pclk;

    canvas_fill #(.DW(DW), .H_LEN(H), .V_LEN(V)) dut (
        .pclk(pclk), .rstn(rstn), .start(start), .clr(clr),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
    );

    int errors = 0;
    int checks = 0;

    // Model state: k = cycles since acceptance (0 = idle), exp_q = expected addresses in order.
    int          k = 0;
    int          np = 0;
    int          exp_q[$];
    logic [11:0] mcolor = '0;
    bit          just_reset = 1'b0;
    bit          started = 1'b0;
    int          done_k = -1;
    bit          noise = 1'b0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int clampv(int v, int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic build_request();
        int a, b, c, d, xa, xb, ya, yb;
        a = clampv(int'(x0), H - 1);
        b = clampv(int'(x1), H - 1);
        c = clampv(int'(y0), V - 1);
        d = clampv(int'(y1), V - 1);
        xa = (a < b) ? a : b;  xb = (a < b) ? b : a;
        ya = (c < d) ? c : d;  yb = (c < d) ? d : c;
        if (clr) begin xa = 0; xb = H - 1; ya = 0; yb = V - 1; end
        exp_q.delete();
        for (int yy = ya; yy <= yb; yy++)
            for (int xx = xa; xx <= xb; xx++)
                exp_q.push_back(yy * H + xx);
        np = exp_q.size();
        mcolor = color;
        done_k = -1;
    endtask

    always @(posedge pclk) begin
        started = 1'b1;
        if (!rstn) begin
            k = 0;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (k == 0) begin
                if (start) begin
                    build_request();
                    k = 1;
                end
            end else begin
                k++;
                if (k == np + 3) k = 0;
            end
        end
    end

    always @(negedge pclk) begin
        if (started) begin
            if (just_reset) begin
                chk("rst_we", int'(we), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_waddr", int'(waddr), 0);
                chk("rst_wdata", int'(wdata), 0);
            end else if (k == 0) begin
                chk("idle_we", int'(we), 0);
                chk("idle_busy", int'(busy), 0);
                chk("idle_done", int'(done), 0);
            end else begin
                chk("busy", int'(busy), int'(k <= np + 1));
                chk("we", int'(we), int'(k >= 2 && k <= np + 1));
                chk("done", int'(done), int'(k == np + 2));
                if (k >= 2 && k <= np + 1) begin
                    chk("waddr", int'(waddr), exp_q[k-2]);
                    chk("wdata", int'(wdata), int'(mcolor));
                    chk("waddr_range", int'(waddr < 15'(H * V)), 1);
                end
                if (done) done_k = k;
            end
        end
    end

    // One request; inj_at injects an extra start at that cycle offset, rst_at pulls rstn there.
    task automatic fill(input logic c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] cc, input logic [7:0] d, input logic [11:0] col,
                        input int inj_at, input int rst_at);
        int n;
        @(posedge pclk); #1;
        clr = c; x0 = a; x1 = b; y0 = cc; y1 = d; color = col; start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        n = 0;
        while (k != 0 && n < 40000) begin
            if (k == rst_at) rstn = 1'b0;
            if (k == inj_at) begin
                start = 1'b1; clr = 1'b0; x0 = 8'd50; x1 = 8'd60; y0 = 8'd20; y1 = 8'd22;
                color = 12'h123;
            end else if (noise && k >= 1 && k < np) begin
                start = ($urandom_range(0, 3) == 0);
                clr = 1'b1; x0 = 8'($urandom); x1 = 8'($urandom);
                y0 = 8'($urandom); y1 = 8'($urandom); color = 12'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge pclk); #1;
            n++;
        end
        start = 1'b0;
        clr = 1'b0;
        rstn = 1'b1;
        if (n >= 40000) chk("timeout", 1, 0);
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1 rstn = 1'b1;

        // Basic 2x2 fill
        fill(1'b0, 8'd0, 8'd1, 8'd0, 8'd1, 12'hF00, -1, -1);
        chk("basic_n", exp_q.size(), 4);
        chk("basic_a0", exp_q[0], 0);
        chk("basic_a1", exp_q[1], 1);
        chk("basic_a2", exp_q[2], 200);
        chk("basic_a3", exp_q[3], 201);
        chk("basic_done_k", done_k, 6);

        // Swapped corners, single row
        fill(1'b0, 8'd5, 8'd3, 8'd10, 8'd10, 12'h0F0, -1, -1);
        chk("swap_n", exp_q.size(), 3);
        chk("swap_a0", exp_q[0], 2003);
        chk("swap_a2", exp_q[2], 2005);
        chk("swap_done_k", done_k, 5);

        // Clamp to bottom-right corner
        fill(1'b0, 8'd198, 8'd250, 8'd149, 8'd200, 12'h00F, -1, -1);
        chk("clamp_n", exp_q.size(), 2);
        chk("clamp_a0", exp_q[0], 29998);
        chk("clamp_a1", exp_q[1], 29999);
        chk("clamp_done_k", done_k, 4);

        // Whole-canvas clear
        fill(1'b1, 8'd7, 8'd9, 8'd7, 8'd9, 12'h0AF, -1, -1);
        chk("clr_n", exp_q.size(), 30000);
        chk("clr_last", exp_q[29999], 29999);
        chk("clr_done_k", done_k, 30002);

        // Start while busy is ignored
        fill(1'b0, 8'd0, 8'd1, 8'd0, 8'd1, 12'hF00, 3, -1);
        chk("busy_start_n", exp_q.size(), 4);
        chk("busy_start_done_k", done_k, 6);

        // Reset mid-fill, then a normal request
        fill(1'b0, 8'd0, 8'd1, 8'd0, 8'd1, 12'hF00, -1, 4);
        chk("rst_no_done", done_k, -1);
        fill(1'b0, 8'd2, 8'd4, 8'd1, 8'd2, 12'hABC, -1, -1);
        chk("after_rst_n", exp_q.size(), 6);
        chk("after_rst_a0", exp_q[0], 202);
        chk("after_rst_done_k", done_k, 8);

        // Randomized small rectangles, with ignored starts sprinkled during fills
        noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, cc;
            a  = 8'($urandom);
            cc = 8'($urandom);
            fill(1'b0, a, a ^ 8'($urandom_range(0, 15)), cc, cc ^ 8'($urandom_range(0, 15)),
                 12'($urandom), -1, -1);
            chk("rand_done_k", done_k, np + 2);
            repeat ($urandom_range(0, 3)) @(posedge pclk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
